// File: rtl/doom_pkg.sv
// Shared definitions for the doom_countdown self-destruct controller:
// state encoding, a constant clog2 and the hazard-vote popcount.
package doom_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2,
        DEAD     = 2'd3
    } state_t;

    // Widest hazard vector the popcount helper accepts.
    localparam int unsigned SENSE_MAX = 16;

    // Ceiling log2 for sizing counters at elaboration time; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        longint unsigned span;
        width = 0;
        span  = 1;
        while (span < longint'(value)) begin
            span  = span << 1;
            width = width + 1;
        end
        return width;
    endfunction

    // Number of set bits in a (zero-extended) hazard vector.
    function automatic logic [4:0] popcount(input logic [SENSE_MAX-1:0] bits);
        logic [4:0] total;
        total = '0;
        for (int unsigned i = 0; i < SENSE_MAX; i++) begin
            total = total + 5'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/sense_debounce.sv
// Single-bit debouncer: the output follows the input only after the input
// has disagreed with it for DEB_CYCLES consecutive clocks.
module sense_debounce
    import doom_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense,
    output logic stable
);

    localparam int unsigned CNT_W = (clog2(DEB_CYCLES) > 0) ? clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count consecutive disagreeing cycles; any bounce back restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt_q  <= '0;
        end else if (sense == stable) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            stable <= sense;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/doom_countdown.sv
// Self-destruct countdown controller: synchronised K-of-N hazard vote drains
// an LED bar one LED per step while in combat, blinking it, and latches a
// sticky DEAD state when the bar empties. Re-arm is honoured only out of combat.
// Optional build macro: SENSE_DEBOUNCE_EN adds a per-bit debouncer on sense.
module doom_countdown
    import doom_pkg::*;
#(
    parameter int unsigned N_SENSE      = 3,
    parameter int unsigned VOTE_K       = 2,
    parameter int unsigned N_LEDS       = 8,
    parameter int unsigned STEP_CYCLES  = 50000000,
    parameter int unsigned BLINK_CYCLES = 16650000,
    parameter int unsigned DEB_CYCLES   = 1500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              combat_i,
    input  logic [N_SENSE-1:0] sense_i,
    input  logic              rearm_i,
    output logic [N_LEDS-1:0] leds_o,
    output logic [1:0]        state_o,
    output logic              dead_o
);

    localparam int unsigned STEP_W  = clog2(STEP_CYCLES);
    localparam int unsigned BLINK_W = clog2(BLINK_CYCLES + 1);

    localparam logic [N_LEDS-1:0] LEVEL_LAST = N_LEDS'(1);

    if (N_SENSE < 1 || N_SENSE > SENSE_MAX || VOTE_K < 1 || VOTE_K > N_SENSE ||
        N_LEDS < 2 || N_LEDS > 32 || STEP_CYCLES < 2 || BLINK_CYCLES < 1 ||
        DEB_CYCLES < 1) begin : g_bad_cfg
        $error("doom_countdown: parameter out of range");
    end

    logic [1:0]         combat_sync;
    logic [1:0]         rearm_sync;
    logic [N_SENSE-1:0] sense_meta;
    logic [N_SENSE-1:0] sense_sync;
    logic [N_SENSE-1:0] sense_vote_in;
    logic               combat_s;
    logic               rearm_s;
    logic               vote_q;

    state_t              state_q, state_d;
    logic [N_LEDS-1:0]   level_q, level_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic                phase_q, phase_d;
    logic [N_LEDS-1:0]   leds_d;
    logic                dead_d;
    logic                step_fire;

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            combat_sync <= '0;
            rearm_sync  <= '0;
            sense_meta  <= '0;
            sense_sync  <= '0;
        end else begin
            combat_sync <= {combat_sync[0], combat_i};
            rearm_sync  <= {rearm_sync[0], rearm_i};
            sense_meta  <= sense_i;
            sense_sync  <= sense_meta;
        end
    end

    assign combat_s = combat_sync[1];
    assign rearm_s  = rearm_sync[1];

`ifdef SENSE_DEBOUNCE_EN
    for (genvar g = 0; g < N_SENSE; g++) begin : g_deb
        sense_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .sense (sense_sync[g]),
            .stable(sense_vote_in[g])
        );
    end
`else
    assign sense_vote_in = sense_sync;
`endif

    // Registered K-of-N hazard vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 1'b0;
        end else begin
            vote_q <= popcount(SENSE_MAX'(sense_vote_in)) >= 5'(VOTE_K);
        end
    end

    assign step_fire = (step_q == STEP_W'(STEP_CYCLES - 1));

    // Next-state, level, counter and output decode.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = step_q;
        blink_d = blink_q;
        phase_d = phase_q;
        leds_d  = '0;
        dead_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (combat_s) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!combat_s) begin
                    state_d = IDLE;
                end else if (vote_q) begin
                    state_d = COUNTING;
                    blink_d = '0;
                    phase_d = 1'b1;
                end
            end
            COUNTING: begin
                // The step counter advances on every counting cycle, including
                // the one that pauses, so a step fire coincident with a vote
                // drop still shifts the bar before dropping to ARMED.
                step_d = step_fire ? '0 : step_q + 1'b1;
                if (blink_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
                if (!combat_s) begin
                    state_d = IDLE;
                end else if (step_fire && level_q == LEVEL_LAST) begin
                    state_d = DEAD;
                end else begin
                    if (step_fire) begin
                        level_d = level_q >> 1;
                    end
                    if (!vote_q) begin
                        state_d = ARMED;
                    end
                end
            end
            DEAD: begin
                if (rearm_s && !combat_s) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Anything landing in IDLE starts over with a full bar.
        if (state_d == IDLE) begin
            level_d = '1;
            step_d  = '0;
            blink_d = '0;
            phase_d = 1'b1;
        end

        unique case (state_d)
            IDLE:     leds_d = '0;
            ARMED:    leds_d = level_d;
            COUNTING: leds_d = phase_d ? level_d : '0;
            DEAD: begin
                leds_d = '1;
                dead_d = 1'b1;
            end
        endcase
    end

    // State, countdown datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '1;
            step_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            leds_o  <= '0;
            dead_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            step_q  <= step_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            leds_o  <= leds_d;
            dead_o  <= dead_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_doom_countdown.sv
// Self-checking bench for doom_countdown (debounce off) with a behavioural
// reference model: the bar level and blink phase are derived from elapsed
// counting cycles rather than from step/blink counters.
module tb_doom_countdown;

    localparam int N_SENSE = 3;
    localparam int VOTE_K  = 2;
    localparam int N_LEDS  = 4;
    localparam int STEP    = 10;
    localparam int BLINK   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              combat;
    logic [N_SENSE-1:0] sense;
    logic              rearm;
    logic [N_LEDS-1:0] leds;
    logic [1:0]        st;
    logic              dead;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    doom_countdown #(
        .N_SENSE     (N_SENSE),
        .VOTE_K      (VOTE_K),
        .N_LEDS      (N_LEDS),
        .STEP_CYCLES (STEP),
        .BLINK_CYCLES(BLINK),
        .DEB_CYCLES  (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .combat_i(combat),
        .sense_i (sense),
        .rearm_i (rearm),
        .leds_o  (leds),
        .state_o (st),
        .dead_o  (dead)
    );

    // Reference model state: 0 idle, 1 armed, 2 counting, 3 dead.
    int               m_state;
    int               run;    // counting cycles since the bar was last full
    int               since;  // counting cycles since entering COUNTING
    logic             m_c1, m_c2, m_r1, m_r2, m_vote;
    logic [N_SENSE-1:0] m_s1, m_s2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        run     = 0;
        since   = 0;
        m_c1 = 0; m_c2 = 0; m_r1 = 0; m_r2 = 0; m_vote = 0;
        m_s1 = '0; m_s2 = '0;
    endtask

    function automatic logic [N_LEDS-1:0] model_level();
        logic [N_LEDS-1:0] full;
        full = '1;
        return full >> (run / STEP);
    endfunction

    function automatic logic [N_LEDS-1:0] model_leds();
        case (m_state)
            1:       return model_level();
            2:       return ((since / BLINK) % 2 == 0) ? model_level() : '0;
            3:       return '1;
            default: return '0;
        endcase
    endfunction

    // One clock edge of the reference, using pre-edge synchronised values.
    task automatic model_edge();
        int nstate;
        nstate = m_state;
        case (m_state)
            0: if (m_c2) nstate = 1;
            1: begin
                if (!m_c2) nstate = 0;
                else if (m_vote) begin
                    nstate = 2;
                    since  = 0;
                end
            end
            2: begin
                if (!m_c2) nstate = 0;
                else if ((run % STEP) == STEP - 1 && (run / STEP) == N_LEDS - 1) nstate = 3;
                else begin
                    run++;
                    since++;
                    if (!m_vote) nstate = 1;
                end
            end
            default: if (m_r2 && !m_c2) nstate = 0;
        endcase
        if (nstate == 0) run = 0;
        m_state = nstate;
        m_vote  = ($countones(m_s2) >= VOTE_K);
        m_c2 = m_c1; m_c1 = combat;
        m_r2 = m_r1; m_r1 = rearm;
        m_s2 = m_s1; m_s1 = sense;
    endtask

    task automatic check_outputs();
        check_eq("state", 32'(st), 32'(m_state));
        check_eq("leds", 32'(leds), 32'(model_leds()));
        check_eq("dead", 32'(dead), 32'(m_state == 3));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Bounded wait until the model reaches a state and counting position.
    task automatic wait_model(input int want_state, input int want_run, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (m_state == want_state && (want_run < 0 || run == want_run)) break;
            tick();
        end
        check_eq("reach_state", 32'(st), 32'(want_state));
    endtask

    int n;

    initial begin
        rst_n  = 1'b0;
        combat = 1'b0;
        sense  = '0;
        rearm  = 1'b0;
        model_reset();
        #1;
        check_eq("reset_state", 32'(st), 0);
        check_eq("reset_leds", 32'(leds), 0);
        check_eq("reset_dead", 32'(dead), 0);
        tick();
        tick();

        // 1: combat with no hazard -> ARMED on the 3rd edge, bar full and steady
        rst_n  = 1'b1;
        combat = 1'b1;
        tick();
        tick();
        check_eq("armed_not_before_3rd", 32'(st), 0);
        tick();
        check_eq("armed_on_3rd", 32'(st), 1);
        for (int k = 0; k < 100; k++) tick();
        check_eq("armed_hold_leds", 32'(leds), 32'hF);

        // 2: vote true -> blink and drain, DEAD after 40 counting cycles
        sense = 3'b101;
        n = 0;
        for (int k = 0; k < 80 && st != 2'd3; k++) begin
            if (st == 2'd2) n++;
            tick();
        end
        check_eq("counting_len", 32'(n), 40);
        check_eq("dead_state", 32'(st), 3);
        check_eq("dead_flag", 32'(dead), 1);
        check_eq("dead_leds", 32'(leds), 32'hF);

        // 5: DEAD is sticky against combat/sense and rearm-in-combat
        for (int k = 0; k < 20; k++) begin
            combat = 1'($urandom);
            sense  = 3'($urandom);
            tick();
        end
        check_eq("dead_sticky", 32'(st), 3);
        combat = 1'b1;
        rearm  = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check_eq("rearm_in_combat", 32'(st), 3);
        combat = 1'b0;
        wait_model(0, -1, 10);
        check_eq("rearm_leds", 32'(leds), 0);
        rearm = 1'b0;
        tick();

        // Vote drop coincident with a step fire: shift applied, then ARMED
        combat = 1'b1;
        sense  = 3'b101;
        wait_model(2, 6, 40);
        sense = 3'b100;
        for (int k = 0; k < 4; k++) tick();
        check_eq("fire_and_pause_state", 32'(st), 1);
        check_eq("fire_and_pause_leds", 32'(leds), 32'h7);

        // 3: pause at level 0011, resume for the remaining step cycles
        sense = 3'b110;
        wait_model(2, 23, 60);
        sense = 3'b100;
        wait_model(1, -1, 10);
        check_eq("pause_leds", 32'(leds), 32'h3);
        for (int k = 0; k < 15; k++) tick();
        check_eq("pause_hold_leds", 32'(leds), 32'h3);
        sense = 3'b110;
        n = 0;
        for (int k = 0; k < 30 && !(st == 2'd2 && run >= 30); k++) begin
            tick();
            n++;
        end
        check_eq("resume_remaining", 32'(n), 7);

        // 4: combat drop beats the final step
        wait_model(2, 37, 40);
        combat = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_eq("drop_beats_final_state", 32'(st), 0);
        check_eq("drop_beats_final_dead", 32'(dead), 0);
        combat = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check_eq("reenter_leds", 32'(leds), 32'hF);

        // 6: asynchronous reset in the middle of a count
        sense = 3'b011;
        wait_model(2, 12, 40);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(st), 0);
        check_eq("async_rst_leds", 32'(leds), 0);
        check_eq("async_rst_dead", 32'(dead), 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // Randomised segments against the reference model
        for (int seg = 0; seg < 120; seg++) begin
            combat = ($urandom_range(0, 9) != 0);
            sense  = 3'($urandom);
            rearm  = ($urandom_range(0, 3) == 0);
            n = $urandom_range(1, 30);
            for (int k = 0; k < n; k++) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
